// File: rtl/prince_sbox_inv_sequencer_pkg.sv
// Shared types and constants for the serial masked inverse S-box sequencer.
package prince_ctrl_pkg;

  localparam int unsigned SBOX_LAT = 3;   // issue -> sb_out* valid
  localparam int unsigned KLMN_LAT = 1;   // issue -> sb_klmn_out1 valid
  localparam int unsigned NIB      = 16;  // nibbles per 64-bit state
  localparam int unsigned RND_W    = 45;  // fresh randomness per nibble

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN
  } state_t;

  // One in-flight nibble: valid marks a real issue, idx is its slot in the state.
  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } tag_t;

endpackage

// File: rtl/prince_sbox_inv_sequencer_if.sv
// PRNG handshake plus the shared masked inverse S-box datapath bus.
interface prince_sbox_inv_sequencer_if;
  import prince_ctrl_pkg::*;

  logic [RND_W-1:0] rnd_data;
  logic             rnd_valid;
  logic             rnd_ready;
  logic [3:0]       sb_in1, sb_in2, sb_in3;
  logic [RND_W-1:0] sb_r;
  logic [1:0]       sb_rc;
  logic [3:0]       sb_klmn_in1;
  logic [5:0]       sb_klmn_in2;
  logic [5:0]       sb_klmn_out1;
  logic [3:0]       sb_out1, sb_out2, sb_out3;

  // Sequencer side.
  modport master (
    input  rnd_data, rnd_valid, sb_klmn_out1, sb_out1, sb_out2, sb_out3,
    output rnd_ready, sb_in1, sb_in2, sb_in3, sb_r, sb_rc, sb_klmn_in1, sb_klmn_in2
  );

  // PRNG / S-box side.
  modport slave (
    output rnd_data, rnd_valid, sb_klmn_out1, sb_out1, sb_out2, sb_out3,
    input  rnd_ready, sb_in1, sb_in2, sb_in3, sb_r, sb_rc, sb_klmn_in1, sb_klmn_in2
  );

endinterface

// File: rtl/prince_tag_pipe.sv
// Valid/index shift register that follows nibbles through the S-box pipeline.
module prince_tag_pipe
  import prince_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = SBOX_LAT,
  parameter int unsigned TAP_A = KLMN_LAT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  tag_t tag_i,
  output logic klmn_vld_o,
  output tag_t out_tap_o
);

  tag_t stage_q [1:DEPTH];

  // Stage k holds the tag issued k cycles ago; bubbles travel as valid=0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 1; k <= DEPTH; k++) stage_q[k] <= '0;
    end else begin
      stage_q[1] <= tag_i;
      for (int unsigned k = 2; k <= DEPTH; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign klmn_vld_o = stage_q[TAP_A].valid;
  assign out_tap_o  = stage_q[DEPTH];

endmodule

// File: rtl/prince_sbox_inv_sequencer.sv
// Serial controller feeding 16 masked nibbles through one shared inverse S-box.
module prince_sbox_inv_sequencer
  import prince_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  rc_cfg,
  input  logic [5:0]  klmn_seed,
  input  logic [63:0] st_in1,
  input  logic [63:0] st_in2,
  input  logic [63:0] st_in3,
  output logic        busy,
  output logic        done,
  output logic [63:0] st_out1,
  output logic [63:0] st_out2,
  output logic [63:0] st_out3,
  prince_sbox_inv_sequencer_if.master sb_bus
);

  state_t      state_q, state_d;
  logic [63:0] sh1_q, sh2_q, sh3_q;
  logic [1:0]  rc_q;
  logic [5:0]  klmn_q;
  logic [3:0]  iss_cnt_q;
  logic [4:0]  cap_cnt_q;
  logic [63:0] st_out1_q, st_out2_q, st_out3_q;
  logic        issue;
  logic        accept;
  logic        klmn_vld;
  tag_t        issue_tag;
  tag_t        out_tap;

  assign accept = (state_q == IDLE) && start;

  // Next-state and handshake decode; done is the DRAIN cycle that sees all captures.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = FEED;
      end
      FEED: begin
        busy  = 1'b1;
        issue = sb_bus.rnd_valid;
        if (issue && (iss_cnt_q == 4'(NIB - 1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (cap_cnt_q == 5'(NIB)) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sb_bus.rnd_ready   = issue;
  assign sb_bus.sb_in1      = issue ? sh1_q[{iss_cnt_q, 2'b00} +: 4] : '0;
  assign sb_bus.sb_in2      = issue ? sh2_q[{iss_cnt_q, 2'b00} +: 4] : '0;
  assign sb_bus.sb_in3      = issue ? sh3_q[{iss_cnt_q, 2'b00} +: 4] : '0;
  assign sb_bus.sb_r        = issue ? sb_bus.rnd_data : '0;
  assign sb_bus.sb_rc       = busy ? rc_q : '0;
  assign sb_bus.sb_klmn_in1 = klmn_q[3:0];
  assign sb_bus.sb_klmn_in2 = klmn_q;

  assign issue_tag = '{valid: issue, idx: iss_cnt_q};

  prince_tag_pipe #(
    .DEPTH (SBOX_LAT),
    .TAP_A (KLMN_LAT)
  ) u_tag_pipe (
    .clk_i      (clk),
    .rst_i      (rst),
    .tag_i      (issue_tag),
    .klmn_vld_o (klmn_vld),
    .out_tap_o  (out_tap)
  );

  // Control state: FSM, latched operands, counters and the klmn refresh chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sh1_q     <= '0;
      sh2_q     <= '0;
      sh3_q     <= '0;
      rc_q      <= '0;
      klmn_q    <= '0;
      iss_cnt_q <= '0;
      cap_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sh1_q     <= st_in1;
        sh2_q     <= st_in2;
        sh3_q     <= st_in3;
        rc_q      <= rc_cfg;
        klmn_q    <= klmn_seed;
        iss_cnt_q <= '0;
        cap_cnt_q <= '0;
      end else begin
        if (issue)         iss_cnt_q <= iss_cnt_q + 4'd1;
        if (out_tap.valid) cap_cnt_q <= cap_cnt_q + 5'd1;
        if (klmn_vld)      klmn_q    <= sb_bus.sb_klmn_out1;
      end
    end
  end

  // Write each returning nibble into its slot; untouched slots keep old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_out1_q <= '0;
      st_out2_q <= '0;
      st_out3_q <= '0;
    end else if (out_tap.valid) begin
      st_out1_q[{out_tap.idx, 2'b00} +: 4] <= sb_bus.sb_out1;
      st_out2_q[{out_tap.idx, 2'b00} +: 4] <= sb_bus.sb_out2;
      st_out3_q[{out_tap.idx, 2'b00} +: 4] <= sb_bus.sb_out3;
    end
  end

  assign st_out1 = st_out1_q;
  assign st_out2 = st_out2_q;
  assign st_out3 = st_out3_q;

endmodule

// File: doc/prince_sbox_inv_sequencer.md
Name: prince_sbox_inv_sequencer

Overview:
- Serial controller that pushes the 16 nibbles of a 3-share masked 64-bit PRINCE state through one shared masked inverse S-box instance (prince_sbox_inverse, 3 registered stages).
- Pulls 45 bits of fresh randomness per nibble from the PRNG over a valid/ready handshake.
- Chains the S-box klmn mask-refresh outputs between nibbles.
- Tracks in-flight nibbles with a tag pipeline and reassembles the three 64-bit output shares.
- Sits between the round-control FSM and the S-box datapath in the area-optimised PRINCE core.

Parameters:
- SBOX_LAT, 3, cycles from S-box input issue to valid sb_out*.
- KLMN_LAT, 1, cycles from issue to valid sb_klmn_out1.
- NIB, 16, nibbles per state. Fixed at 16; the parameter exists for readability only.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin operation; accepted only in IDLE
- rc_cfg  in  2  value forwarded to sb_rc; sampled on start
- klmn_seed  in  6  initial klmn chain value; sampled on start
- st_in1, st_in2, st_in3  in  64 each  input state shares
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse; st_out* valid from this cycle
- st_out1, st_out2, st_out3  out  64 each  output state shares; held until next start
- rnd_data  in  45  fresh randomness
- rnd_valid  in  1  PRNG has data
- rnd_ready  out  1  controller consumes rnd_data this cycle
- sb_in1, sb_in2, sb_in3  out  4 each  S-box input shares
- sb_r  out  45  S-box randomness
- sb_rc  out  2  S-box constant select
- sb_klmn_in1  out  4  S-box klmn_in1
- sb_klmn_in2  out  6  S-box klmn_in2
- sb_klmn_out1  in  6  S-box klmn_out1
- sb_out1, sb_out2, sb_out3  in  4 each  S-box output shares

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, issue and capture counters 0, tag pipeline cleared, klmn_q = 0. Reset mid-operation aborts immediately: no done pulse, and nibbles in flight are discarded.
- FSM states:
  - IDLE: start=1 latches st_in*, rc_cfg and klmn_seed (klmn_seed into klmn_q), sets busy, and moves to FEED. Start in any other state is ignored.
  - FEED: issue occurs when rnd_valid=1; rnd_ready is combinationally equal to rnd_valid in FEED and 0 elsewhere.
    - On issue: sb_in* = latched share nibble [4*i+3:4*i], where i is the issue counter (nibble 0 first); sb_r = rnd_data; the issue counter increments.
    - On no issue: sb_in* = 0 and sb_r = 0.
    - After issuing nibble 15, move to DRAIN.
  - DRAIN: wait until the capture counter reaches 16, then assert done for one cycle, clear busy, and return to IDLE.
- sb_rc = latched rc_cfg whenever busy; 0 otherwise.
- Tag pipeline: a SBOX_LAT-deep shift register of (valid, 4-bit index); valid is set on issue cycles only. Bubbles carry valid=0.
- Capture: in any cycle where tag stage SBOX_LAT is valid, sb_out1/2/3 are written into st_out1/2/3 at the tagged nibble index at the end of that cycle, and the capture counter increments.
- klmn chaining:
  - sb_klmn_in1 = klmn_q[3:0] and sb_klmn_in2 = klmn_q at all times.
  - klmn_q <= sb_klmn_out1 at the end of any cycle where tag stage KLMN_LAT is valid.
  - Bubbles never update klmn_q.
  - With back-to-back issue, nibble i therefore uses the klmn produced by nibble i-2; nibbles 0 and 1 use klmn_seed.
- Latency: with start accepted at cycle T and rnd_valid held high, issues occur at T+1..T+16, the last capture at T+16+SBOX_LAT, and done at T+17+SBOX_LAT (T+20 by default). Each cycle of rnd_valid=0 during FEED adds exactly one cycle.
- rnd_valid dropping in DRAIN has no effect. done and a new start in the same cycle is impossible, because start is sampled only in IDLE.
- st_out* are not cleared on start; only the slots of captured nibbles change.

Decomposition:
- Package prince_ctrl_pkg holds:
  - an FSM state enum (IDLE, FEED, DRAIN);
  - the constants SBOX_LAT, KLMN_LAT, NIB and RND_W=45;
  - a typedef for the tag entry struct {valid, idx[3:0]}.
- One sub-module: prince_tag_pipe, a parameterised valid/index shift register exposing its stage-KLMN_LAT and stage-SBOX_LAT taps.

Test Plan:
- Functional, no stalls: unmasked input 0x0123456789ABCDEF split into random shares, rc_cfg=0, rnd_valid=1 throughout. Required: XOR of st_out* = 0xB732FD89A6405EC1, done exactly 20 cycles after start, busy high from T+1 through T+19.
- Stall pattern: rnd_valid toggles 1,0,1,0 during FEED. Required: exactly 16 transfers, the same unmasked result, done delayed by the number of stall cycles, and sb_in*=0 with no tag valid on bubble cycles.
- klmn chaining: klmn_seed=0x2A with the S-box model's klmn_out1 returning 0x10+index. Required: nibbles 0 and 1 see sb_klmn_in2=0x2A, and nibble k≥2 sees 0x10+(k-2).
- Start while busy: pulse start at cycles T+5 and T+18. Required: both ignored, one done pulse, latched shares unchanged.
- Reset mid-operation: assert rst at cycle T+8. Required: all outputs 0 on the next cycle, no done pulse, and a subsequent start completes correctly in 20 cycles.
- Masking sanity: the same unmasked input under two different share splits and rnd streams. Required: identical unmasked result, and different st_out1 values.
